// File: rtl/hex2dec_arb.sv
// hex2dec_arb: round-robin arbiter sharing one binary-to-BCD converter
// between NREQ valid/ready requesters, with one valid/ready response channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NREQ]       per-requester request valid
//   req_data[8*NREQ]      per-requester byte, requester i on [8i+7:8i]
//   req_ready[NREQ]       one-hot acceptance strobe (combinational, IDLE only)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the served requester
//   rsp_dec_h/rsp_dec_l   BCD tens/units digits (F/F on error)
//   rsp_err               served byte was greater than 99
//   stat_done/stat_err    response counters
//
// Optional feature macro: HEX2DEC_ARB_STATS_EN enables the response counters;
// without it stat_done and stat_err are tied to zero.
module hex2dec_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_dec_h,
  output logic [3:0]        rsp_dec_l,
  output logic              rsp_err,
  output logic [15:0]       stat_done,
  output logic [7:0]        stat_err
);

  localparam int unsigned DW     = 8;
  localparam int unsigned DIGW   = 4;
  localparam int unsigned MAXDEC = 99;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   conv_in_q, conv_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DIGW-1:0] rsp_dec_h_q, rsp_dec_h_d;
  logic [DIGW-1:0] rsp_dec_l_q, rsp_dec_l_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found_c;
  logic [IDW-1:0]  gnt_idx_c;
  logic [DW-1:0]   gnt_data_c;
  logic [DIGW-1:0] conv_h_c, conv_l_c;
  logic            conv_err_c;
  logic            rsp_fire_c;

  // Requester index k positions after the pointer, wrapping at NREQ.
  function automatic int unsigned wrap_idx(input logic [IDW-1:0] ptr, input int unsigned k);
    int unsigned idx;
    idx = int'(ptr) + k;
    if (idx >= NREQ) idx = idx - NREQ;
    return idx;
  endfunction

  // Round-robin search starting at rr_ptr.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    gnt_data_c  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_found_c && req_valid[wrap_idx(rr_ptr_q, k)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = IDW'(wrap_idx(rr_ptr_q, k));
        gnt_data_c  = req_data[DW*wrap_idx(rr_ptr_q, k) +: DW];
      end
    end
  end

  // Shared converter; only meaningful for 0..99, error overrides otherwise.
  always_comb begin
    conv_h_c   = DIGW'(conv_in_q / DW'(10));
    conv_l_c   = DIGW'(conv_in_q % DW'(10));
    conv_err_c = (conv_in_q > DW'(MAXDEC));
  end

  // Acceptance strobe held low during reset so no transfer overlaps it.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_found_c) req_ready[gnt_idx_c] = 1'b1;
  end

  assign rsp_fire_c = rsp_valid_q & rsp_ready;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    conv_in_d   = conv_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_dec_h_d = rsp_dec_h_q;
    rsp_dec_l_d = rsp_dec_l_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found_c) begin
          conv_in_d = gnt_data_c;
          id_d      = gnt_idx_c;
          rr_ptr_d  = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
          state_d   = CONV;
        end
      end
      CONV: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = conv_err_c;
        rsp_dec_h_d = conv_err_c ? 4'hF : conv_h_c;
        rsp_dec_l_d = conv_err_c ? 4'hF : conv_l_c;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_fire_c) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      conv_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_dec_h_q <= '0;
      rsp_dec_l_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      conv_in_q   <= conv_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dec_h_q <= rsp_dec_h_d;
      rsp_dec_l_q <= rsp_dec_l_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dec_h = rsp_dec_h_q;
  assign rsp_dec_l = rsp_dec_l_q;
  assign rsp_err   = rsp_err_q;

`ifdef HEX2DEC_ARB_STATS_EN
  logic [15:0] stat_done_q, stat_done_d;
  logic [7:0]  stat_err_q, stat_err_d;

  // Done count wraps; error count saturates.
  always_comb begin
    stat_done_d = stat_done_q;
    stat_err_d  = stat_err_q;
    if (rsp_fire_c) begin
      stat_done_d = stat_done_q + 16'd1;
      if (rsp_err_q && (stat_err_q != 8'hFF)) stat_err_d = stat_err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;
`else
  assign stat_done = '0;
  assign stat_err  = '0;
`endif

endmodule
